// File: rtl/adc_conv_arbiter_if.sv
// Bundles the requester handshake and the ADC mux/converter signals seen by adc_conv_arbiter.
// master is the environment (requesters plus converter); slave is the arbiter.
interface adc_conv_arbiter_if #(
    parameter int unsigned FP_WIDTH = 32
);
    logic                req0;
    logic                req1;
    logic                sel0;
    logic                sel1;
    logic                ack0;
    logic                ack1;
    logic [FP_WIDTH-1:0] result;
    logic                res_err;
    logic                adc_sel;
    logic                adc_en;
    logic                conv_rst;
    logic                adc_done;
    logic [FP_WIDTH-1:0] adc_cal_in;

    modport master (
        output req0, req1, sel0, sel1, adc_done, adc_cal_in,
        input  ack0, ack1, result, res_err, adc_sel, adc_en, conv_rst
    );

    modport slave (
        input  req0, req1, sel0, sel1, adc_done, adc_cal_in,
        output ack0, ack1, result, res_err, adc_sel, adc_en, conv_rst
    );
endinterface

// File: rtl/adc_conv_arbiter.sv
// Round-robin arbiter sharing one ADC mux/converter path between two requesters,
// with channel settle delay, EN/DONE sequencing and a timeout flush.
module adc_conv_arbiter #(
    parameter int unsigned FP_WIDTH       = 32,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              adc_clk,
    input  logic              reg_rst,
    input  logic              sys_en,
    adc_conv_arbiter_if.slave bus,
    output logic              busy,
    output logic              grant,
    output logic [7:0]        err_cnt
);
    localparam int unsigned    ToW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned    StW    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);
    localparam logic [StW-1:0] StInit = StW'(SETTLE_CYCLES);

    typedef enum logic [1:0] {StIdle, StSettle, StConv, StFlush} state_e;

    state_e              state_q, state_d;
    logic [ToW-1:0]      to_cnt_q, to_cnt_d;
    logic [StW-1:0]      st_cnt_q, st_cnt_d;
    logic                last_q, last_d;
    logic                grant_q, grant_d;
    logic                sel_q, sel_d;
    logic                en_q, en_d;
    logic                crst_q, crst_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                res_err_q, res_err_d;
    logic                busy_q, busy_d;
    logic [FP_WIDTH-1:0] result_q, result_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic                win;
    logic                win_sel;

    always_comb begin
        // On a tie the requester not served last wins
        win     = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
        win_sel = win ? bus.sel1 : bus.sel0;

        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        st_cnt_d  = st_cnt_q;
        last_d    = last_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        en_d      = 1'b0;
        crst_d    = 1'b0;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        res_err_d = res_err_q;
        result_d  = result_q;
        err_cnt_d = err_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (sys_en && (bus.req0 || bus.req1)) begin
                    grant_d = win;
                    sel_d   = win_sel;
                    if (win_sel != sel_q) begin
                        state_d  = StSettle;
                        st_cnt_d = StInit;
                    end else begin
                        state_d  = StConv;
                        en_d     = 1'b1;
                        to_cnt_d = '0;
                    end
                end
            end
            StSettle: begin
                if (st_cnt_q == StW'(1)) begin
                    state_d  = StConv;
                    en_d     = 1'b1;
                    to_cnt_d = '0;
                end else begin
                    st_cnt_d = st_cnt_q - 1'b1;
                end
            end
            StConv: begin
                // DONE is checked first so it wins over an expiring timeout
                if (bus.adc_done) begin
                    result_d  = bus.adc_cal_in;
                    res_err_d = 1'b0;
                    ack0_d    = ~grant_q;
                    ack1_d    = grant_q;
                    last_d    = grant_q;
                    state_d   = StIdle;
                end else if (to_cnt_q == ToLast) begin
                    state_d   = StFlush;
                    crst_d    = 1'b1;
                    result_d  = '0;
                    res_err_d = 1'b1;
                    ack0_d    = ~grant_q;
                    ack1_d    = grant_q;
                    last_d    = grant_q;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end else begin
                    en_d     = 1'b1;
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StFlush: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge adc_clk) begin
        if (reg_rst) begin
            state_q   <= StIdle;
            to_cnt_q  <= '0;
            st_cnt_q  <= '0;
            last_q    <= 1'b1;
            grant_q   <= 1'b0;
            sel_q     <= 1'b1;
            en_q      <= 1'b0;
            crst_q    <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            res_err_q <= 1'b0;
            busy_q    <= 1'b0;
            result_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            st_cnt_q  <= st_cnt_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            en_q      <= en_d;
            crst_q    <= crst_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            res_err_q <= res_err_d;
            busy_q    <= busy_d;
            result_q  <= result_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.result   = result_q;
    assign bus.res_err  = res_err_q;
    assign bus.adc_sel  = sel_q;
    assign bus.adc_en   = en_q;
    assign bus.conv_rst = crst_q;
    assign busy         = busy_q;
    assign grant        = grant_q;
    assign err_cnt      = err_cnt_q;
endmodule

// File: tb/tb_adc_conv_arbiter.sv
// Self-checking bench for adc_conv_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of grants, settle time and conversion outcome.
module tb_adc_conv_arbiter;
    localparam int unsigned FpW    = 32;
    localparam int unsigned Settle = 4;
    localparam int unsigned Tmo    = 16;

    logic       adc_clk = 1'b0;
    logic       reg_rst;
    logic       sys_en;
    logic       busy;
    logic       grant;
    logic [7:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    // Transaction-level model state
    int          last_m;
    bit          sel_m;
    int          err_m;
    logic [31:0] res_m;
    int          w_m;
    bit          wsel_m;

    adc_conv_arbiter_if #(.FP_WIDTH(FpW)) bus ();

    adc_conv_arbiter #(
        .FP_WIDTH      (FpW),
        .SETTLE_CYCLES (Settle),
        .TIMEOUT_CYCLES(Tmo)
    ) dut (
        .adc_clk(adc_clk),
        .reg_rst(reg_rst),
        .sys_en (sys_en),
        .bus    (bus.slave),
        .busy   (busy),
        .grant  (grant),
        .err_cnt(err_cnt)
    );

    always #5 adc_clk = ~adc_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic model_reset();
        last_m = 1;
        sel_m  = 1'b1;
        err_m  = 0;
        res_m  = '0;
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk({tag, ".idle"}, {bus.ack0, bus.ack1, busy, bus.adc_en, bus.conv_rst}, 32'd0);
        end
    endtask

    // Arbitrate, then count cycles with EN low before it rises
    task automatic grant_phase(input string tag);
        int n = 0;
        bit settle;
        if (bus.req0 && bus.req1) w_m = 1 - last_m;
        else                      w_m = bus.req1 ? 1 : 0;
        wsel_m = (w_m == 1) ? bus.sel1 : bus.sel0;
        settle = (wsel_m != sel_m);
        sel_m  = wsel_m;
        step();
        chk({tag, ".grant"}, {busy, grant, bus.adc_sel}, {29'd0, 1'b1, 1'(w_m), wsel_m});
        while (!bus.adc_en && n < int'(Settle) + 4) begin
            chk({tag, ".settle"}, {bus.ack0, bus.ack1, bus.conv_rst, busy, bus.adc_sel},
                {28'd0, 1'b1, wsel_m});
            step();
            n++;
        end
        chk({tag, ".settle_cycles"}, 32'(n), settle ? 32'(Settle) : 32'd0);
    endtask

    // Drive DONE once EN has been high d+1 cycles (never, if d >= Tmo)
    task automatic conv_phase(input string tag, input int d, input logic [31:0] cal);
        int en_seen = 1;
        bit tmo;
        bus.adc_cal_in = cal;
        for (int i = 0; i < int'(Tmo) + 4; i++) begin
            if (en_seen == d + 1) bus.adc_done = 1'b1;
            step();
            bus.adc_done = 1'b0;
            if (!bus.adc_en) break;
            chk({tag, ".conv"}, {bus.ack0, bus.ack1, bus.conv_rst}, 32'd0);
            en_seen++;
        end
        tmo = (d >= int'(Tmo));
        chk({tag, ".en_cycles"}, 32'(en_seen), tmo ? 32'(Tmo) : 32'(d + 1));
        if (tmo) begin
            res_m = '0;
            err_m = (err_m < 255) ? err_m + 1 : 255;
        end else begin
            res_m = cal;
        end
        last_m = w_m;
        chk({tag, ".ack"}, {bus.ack0, bus.ack1}, (w_m == 0) ? 32'd2 : 32'd1);
        chk({tag, ".result"}, bus.result, res_m);
        chk({tag, ".flags"}, {bus.res_err, bus.conv_rst, busy, bus.adc_en},
            {28'd0, tmo, tmo, tmo, 1'b0});
        chk({tag, ".err_cnt"}, {24'd0, err_cnt}, 32'(err_m));
        if (tmo) idle_check({tag, ".post_flush"}, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] r;
        int         d;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.sel0 = 1'b1; bus.sel1 = 1'b1;
        bus.adc_done = 1'b0; bus.adc_cal_in = '0;
        sys_en = 1'b1;
        reg_rst = 1'b1;
        step();
        step();
        reg_rst = 1'b0;
        model_reset();
        chk("reset.ctl", {bus.adc_sel, bus.adc_en, bus.conv_rst, busy, grant}, 32'h10);
        chk("reset.ack", {bus.ack0, bus.ack1, bus.res_err}, 32'd0);
        chk("reset.result", bus.result, 32'd0);
        chk("reset.err_cnt", {24'd0, err_cnt}, 32'd0);

        // Single request on the current channel: no settle
        bus.req0 = 1'b1; bus.sel0 = 1'b1;
        grant_phase("t1");
        conv_phase("t1", 3, 32'h0001_2345);
        bus.req0 = 1'b0;
        idle_check("t1", 3);

        // Both held on different channels: alternate with settle each switch
        bus.req0 = 1'b1; bus.sel0 = 1'b1; bus.req1 = 1'b1; bus.sel1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            grant_phase($sformatf("alt%0d", i));
            conv_phase($sformatf("alt%0d", i), 1, $urandom);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        idle_check("alt", 2);

        // Timeout, then DONE exactly on the last allowed cycle
        bus.req0 = 1'b1; bus.sel0 = sel_m;
        grant_phase("tmo");
        conv_phase("tmo", int'(Tmo) + 3, $urandom);
        bus.req0 = 1'b0;
        idle_check("tmo", 1);
        bus.req0 = 1'b1;
        grant_phase("edge");
        conv_phase("edge", int'(Tmo) - 1, 32'hCAFE_0001);
        bus.req0 = 1'b0;
        idle_check("edge", 1);

        // Spurious DONE while idle
        bus.adc_done = 1'b1; bus.adc_cal_in = 32'h1234_5678;
        idle_check("spur", 3);
        bus.adc_done = 1'b0;
        chk("spur.result", bus.result, res_m);

        // SYS_EN drop mid-conversion with requester 1 waiting
        bus.req0 = 1'b1; bus.sel0 = sel_m;
        grant_phase("sysen");
        sys_en = 1'b0;
        bus.req1 = 1'b1; bus.sel1 = 1'($urandom);
        conv_phase("sysen", 3, $urandom);
        bus.req0 = 1'b0;
        idle_check("sysen_hold", 4);
        sys_en = 1'b1;
        grant_phase("sysen_resume");
        conv_phase("sysen_resume", 2, $urandom);
        bus.req1 = 1'b0;
        idle_check("sysen", 1);

        // Reset while converting
        bus.req0 = 1'b1; bus.sel0 = 1'($urandom);
        grant_phase("rst");
        step();
        step();
        reg_rst = 1'b1; bus.req0 = 1'b0;
        step();
        reg_rst = 1'b0;
        model_reset();
        chk("rst.ctl", {bus.adc_sel, bus.adc_en, bus.conv_rst, busy, grant}, 32'h10);
        chk("rst.ack", {bus.ack0, bus.ack1, bus.res_err, err_cnt}, 32'd0);
        bus.req0 = 1'b1; bus.sel0 = 1'b0;
        grant_phase("rst_after");
        conv_phase("rst_after", 0, 32'h0BAD_F00D);
        bus.req0 = 1'b0;
        idle_check("rst_after", 1);

        // Randomized transactions, sometimes back-to-back
        for (int k = 0; k < 40; k++) begin
            if (k == 0 || !bus.req0 && !bus.req1 || $urandom_range(0, 1) == 0) begin
                r = 2'($urandom_range(1, 3));
                bus.req0 = r[0]; bus.req1 = r[1];
                bus.sel0 = 1'($urandom); bus.sel1 = 1'($urandom);
            end
            d = ($urandom_range(0, 7) == 0) ? int'(Tmo) + int'($urandom_range(0, 2))
                                            : int'($urandom_range(0, Tmo - 1));
            grant_phase($sformatf("rnd%0d", k));
            conv_phase($sformatf("rnd%0d", k), d, $urandom);
            if ($urandom_range(0, 1) == 1) begin
                bus.req0 = 1'b0; bus.req1 = 1'b0;
                idle_check($sformatf("rnd%0d", k), 1);
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        idle_check("rnd", 1);

        // Error counter saturation
        bus.req0 = 1'b1; bus.sel0 = sel_m;
        for (int i = 0; i < 300; i++) begin
            grant_phase("sat");
            conv_phase("sat", int'(Tmo) + 5, $urandom);
        end
        bus.req0 = 1'b0;
        idle_check("sat", 1);
        chk("sat.final", {24'd0, err_cnt}, 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
